// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV64I-subset core: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath strobe and mux select.
module multicycle_control_fsm #(
  parameter int INST_W        = 32,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALUCTRL_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INST_W-1:0]    inst,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [2:0]           imm_src,
  output logic [1:0]           result_src,
  output logic [3:0]           state_dbg,
  output logic                 illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_AUIPC    = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_e     state_q, state_d;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       funct7b5_s;
  logic       ready_s;
  logic       r_legal_s;
  logic [2:0] r_alu_s;
  logic       pc_write_s, adr_src_s, mem_write_s, ir_write_s, reg_write_s, illegal_s;
  logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
  logic [2:0] alu_s, imm_s;
  logic       unused_fields;

  assign opcode_s      = inst[6:0];
  assign funct3_s      = inst[14:12];
  assign funct7b5_s    = inst[30];
  assign ready_s       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

  if (INST_W > 32) begin : g_wide_inst
    logic unused_hi;
    assign unused_hi = ^inst[INST_W-1:32];
  end

  // State register: reset abandons any instruction and returns to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // R-type ALU operation from {funct7[5], funct3}; unsupported pairs are illegal.
  always_comb begin
    r_legal_s = 1'b1;
    r_alu_s   = 3'b000;
    case ({funct7b5_s, funct3_s})
      4'b0000: r_alu_s = 3'b000;
      4'b1000: r_alu_s = 3'b001;
      4'b0111: r_alu_s = 3'b010;
      4'b0110: r_alu_s = 3'b011;
      4'b0010: r_alu_s = 3'b101;
      default: r_legal_s = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_s)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_AUIPC:     state_d = S_AUIPC;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (funct3_s != 3'b011) begin
          state_d = S_TRAP;
        end else if (opcode_s == OP_LD) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_d = ready_s ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = ready_s ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = r_legal_s ? S_ALUWB : S_TRAP;
      S_EXECI:    state_d = (funct3_s == 3'b000) ? S_ALUWB : S_TRAP;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = (funct3_s[2:1] == 2'b00) ? S_FETCH : S_TRAP;
      S_JAL:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; BRANCH and the memory handshake are the only input-dependent strobes.
  always_comb begin
    pc_write_s   = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    alu_s        = 3'b000;
    case (state_q)
      S_FETCH: begin
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = ready_s;
        pc_write_s   = ready_s;
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEMREAD: adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_s = 2'b10;
        alu_s       = r_alu_s;
      end
      S_EXECI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_s       = 3'b001;
        case (funct3_s)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = !zero;
          default: pc_write_s = 1'b0;
        endcase
      end
      S_JAL: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b10;
        pc_write_s  = 1'b1;
      end
      S_AUIPC: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (opcode_s)
      OP_LD, OP_I: imm_s = 3'b000;
      OP_SD:       imm_s = 3'b001;
      OP_B:        imm_s = 3'b010;
      OP_JAL:      imm_s = 3'b011;
      OP_AUIPC:    imm_s = 3'b100;
      default:     imm_s = 3'b000;
    endcase
  end

  // Write strobes are gated directly by rst_n so they drop the moment reset asserts.
  assign pc_write    = pc_write_s  & rst_n;
  assign ir_write    = ir_write_s  & rst_n;
  assign reg_write   = reg_write_s & rst_n;
  assign mem_write   = mem_write_s & rst_n;
  assign adr_src     = adr_src_s;
  assign alu_src_a   = alu_src_a_s;
  assign alu_src_b   = alu_src_b_s;
  assign alu_control = ALUCTRL_W'(alu_s);
  assign imm_src     = imm_s;
  assign result_src  = result_src_s;
  assign state_dbg   = state_q;
  assign illegal     = illegal_s;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which is compared with the DUT.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw, ill;
    logic [1:0] a, b, rs;
    logic [2:0] alu, imm;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control, imm_src;
  logic [3:0]  state_dbg;

  int nchk = 0;
  int nerr = 0;
  entry_t     exp_q[$];
  entry_t     obs_q[$];
  logic [1:0] drv_q[$];

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .result_src(result_src),
    .state_dbg(state_dbg), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic entry_t sample();
    entry_t o;
    o.st = state_dbg; o.pcw = pc_write; o.adr = adr_src; o.mw = mem_write;
    o.irw = ir_write; o.rw = reg_write; o.ill = illegal; o.a = alu_src_a;
    o.b = alu_src_b; o.rs = result_src; o.alu = alu_control; o.imm = imm_src;
    return o;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h03, 7'h13: return 3'd0;
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h6F:        return 3'd3;
      7'h17:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic entry_t blank(input logic [3:0] st, input logic [31:0] ins);
    entry_t e;
    e = '0;
    e.st = st;
    e.imm = imm_of(ins[6:0]);
    return e;
  endfunction

  task automatic push(input entry_t e, input logic rdy, input logic zr);
    exp_q.push_back(e);
    drv_q.push_back({rdy, zr});
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: the expected cycle-by-cycle controls for one instruction.
  task automatic build(input logic [31:0] ins, input int fwait, input int mwait,
                       input logic zbr, output bit trapped);
    entry_t e;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit to_wb = 1'b0;
    trapped = 1'b0;
    e = blank(4'd0, ins); e.b = 2'd2; e.rs = 2'd2;
    for (int w = 0; w < fwait; w++) push(e, 1'b0, rb());
    e.pcw = 1'b1; e.irw = 1'b1; push(e, 1'b1, rb());
    e = blank(4'd1, ins); e.a = 2'd1; e.b = 2'd1; push(e, rb(), rb());
    if (op == 7'h03 || op == 7'h23) begin
      e = blank(4'd2, ins); e.a = 2'd2; e.b = 2'd1; push(e, rb(), rb());
      if (f3 != 3'd3) trapped = 1'b1;
      else if (op == 7'h03) begin
        e = blank(4'd3, ins); e.adr = 1'b1;
        for (int w = 0; w < mwait; w++) push(e, 1'b0, rb());
        push(e, 1'b1, rb());
        e = blank(4'd4, ins); e.rs = 2'd1; e.rw = 1'b1; push(e, rb(), rb());
      end else begin
        e = blank(4'd5, ins); e.adr = 1'b1; e.mw = 1'b1;
        for (int w = 0; w < mwait; w++) push(e, 1'b0, rb());
        push(e, 1'b1, rb());
      end
    end else if (op == 7'h33) begin
      e = blank(4'd6, ins); e.a = 2'd2;
      case ({ins[30], f3})
        4'b0000: to_wb = 1'b1;
        4'b1000: begin e.alu = 3'd1; to_wb = 1'b1; end
        4'b0111: begin e.alu = 3'd2; to_wb = 1'b1; end
        4'b0110: begin e.alu = 3'd3; to_wb = 1'b1; end
        4'b0010: begin e.alu = 3'd5; to_wb = 1'b1; end
        default: trapped = 1'b1;
      endcase
      push(e, rb(), rb());
    end else if (op == 7'h13) begin
      e = blank(4'd7, ins); e.a = 2'd2; e.b = 2'd1; push(e, rb(), rb());
      if (f3 == 3'd0) to_wb = 1'b1; else trapped = 1'b1;
    end else if (op == 7'h63) begin
      e = blank(4'd9, ins); e.a = 2'd2; e.alu = 3'd1;
      if (f3 == 3'd0) e.pcw = zbr;
      else if (f3 == 3'd1) e.pcw = !zbr;
      else trapped = 1'b1;
      push(e, rb(), zbr);
    end else if (op == 7'h6F) begin
      e = blank(4'd10, ins); e.a = 2'd1; e.b = 2'd2; e.pcw = 1'b1; push(e, rb(), rb());
      to_wb = 1'b1;
    end else if (op == 7'h17) begin
      e = blank(4'd11, ins); e.a = 2'd1; e.b = 2'd1; push(e, rb(), rb());
      to_wb = 1'b1;
    end else begin
      trapped = 1'b1;
    end
    if (to_wb) begin
      e = blank(4'd8, ins); e.rw = 1'b1; push(e, rb(), rb());
    end
    if (trapped) begin
      e = blank(4'd12, ins); e.ill = 1'b1;
      for (int k = 0; k < 3; k++) push(e, 1'b1, rb());
    end
  endtask

  // Drives the queued inputs one cycle at a time and records the DUT outputs.
  task automatic play(input logic [31:0] ins);
    inst = ins;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      {mem_ready, zero} = drv_q[i];
      #1;
      obs_q.push_back(sample());
      @(negedge clk);
    end
  endtask

  task automatic clear();
    exp_q.delete();
    drv_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    entry_t e;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; inst = 32'h002081B3;
    e = blank(4'd0, inst); e.b = 2'd2; e.rs = 2'd2;
    for (int k = 0; k < 2; k++) begin
      #1;
      nchk++;
      if (sample() !== e) begin
        nerr++;
        $display("FAIL reset k=%0d got=%h exp=%h", k, sample(), e);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seq(input string name, input logic [31:0] ins, input int fwait,
                          input int mwait, input logic zbr);
    bit tr;
    clear();
    build(ins, fwait, mwait, zbr, tr);
    play(ins);
    foreach (exp_q[i]) begin
      nchk++;
      if (obs_q[i] !== exp_q[i]) begin
        nerr++;
        $display("FAIL %s cyc=%0d got st=%0d v=%h exp st=%0d v=%h", name, i,
                 obs_q[i].st, obs_q[i], exp_q[i].st, exp_q[i]);
      end
    end
    if (tr) do_reset();
  endtask

  task automatic test_plan_details();
    test_seq("add", 32'h002081B3, 0, 0, 1'b0);
    nchk++;
    if (exp_q.size() != 4) begin
      nerr++;
      $display("FAIL add_latency got=%0d exp=4", exp_q.size());
    end
    test_seq("sub", 32'h402081B3, 0, 0, 1'b0);
    nchk++;
    if (obs_q[2].alu !== 3'b001) begin
      nerr++;
      $display("FAIL sub_alu got=%b exp=001", obs_q[2].alu);
    end
    test_seq("ld_wait", 32'h0000B283, 0, 2, 1'b0);
    test_seq("sd_wait", 32'h0050B423, 0, 3, 1'b0);
    test_seq("beq_taken", 32'h00000463, 0, 0, 1'b1);
    test_seq("bne_not", 32'h00001463, 0, 0, 1'b1);
    test_seq("jal", 32'h010000EF, 0, 0, 1'b0);
    test_seq("bad_op", 32'h0000007F, 0, 0, 1'b0);
    test_seq("fetch_wait", 32'h00508093, 2, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit tr;
    clear();
    build(32'h0050B423, 0, 3, 1'b0, tr);
    while (exp_q.size() > 5) begin
      void'(exp_q.pop_back());
      void'(drv_q.pop_back());
    end
    play(32'h0050B423);
    mem_ready = 1'b0;
    #1;
    nchk++;
    if (mem_write !== 1'b1 || state_dbg !== 4'd5) begin
      nerr++;
      $display("FAIL pre_reset got mw=%b st=%0d exp mw=1 st=5", mem_write, state_dbg);
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    nchk++;
    if (mem_write !== 1'b0 || state_dbg !== 4'd0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset got mw=%b st=%0d pcw=%b irw=%b exp 0/0/0/0",
               mem_write, state_dbg, pc_write, ir_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back_random();
    logic [6:0]  ops[7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h17};
    logic [3:0]  rsel[5] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0010};
    logic [31:0] ins;
    logic [3:0]  fr;
    int idx;
    for (int n = 0; n < 120; n++) begin
      ins = $urandom;
      idx = $urandom_range(0, 7);
      if (idx < 7) ins[6:0] = ops[idx];
      if ($urandom_range(0, 3) != 0) begin
        case (ins[6:0])
          7'h03, 7'h23: ins[14:12] = 3'd3;
          7'h13:        ins[14:12] = 3'd0;
          7'h63:        ins[14:12] = 3'($urandom_range(0, 1));
          7'h33: begin
            fr = rsel[$urandom_range(0, 4)];
            ins[30] = fr[3];
            ins[14:12] = fr[2:0];
          end
          default: ins[14:12] = ins[14:12];
        endcase
      end
      test_seq("random", ins, $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_plan_details();
    test_reset_mid();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name:
multicycle_control_fsm

Overview:
- Main control unit for the multicycle RV64I-subset processor. It replaces the purely combinational opcode decoder with a state machine that sequences fetch, decode, execute, memory and writeback.
- Drives every datapath strobe and mux select per state.
- Adds a memory wait-state handshake, branch resolution for beq/bne, and an illegal-instruction trap.

Parameters:
- INST_W, 32: instruction input width. Only [31:0] is decoded; upper bits are ignored.
- MEM_HANDSHAKE, 1: 1 means the memory states wait on mem_ready; 0 means mem_ready is treated as constant 1.
- ALUCTRL_W, 3: width of alu_control.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inst  in  INST_W  instruction register output
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  unified memory access done
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A
- alu_src_b  out  2  00 = register B, 01 = ImmExt, 10 = constant 4
- alu_control  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- result_src  out  2  00 = ALUOut, 01 = Data register, 10 = ALU result
- state_dbg  out  4  current state encoding
- illegal  out  1  high while in TRAP

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, AUIPC 11, TRAP 12.
- Output model:
  - All outputs are Moore, from state, except: pc_write in BRANCH, handshake-gated strobes, and imm_src/alu_control decode.
  - Unlisted outputs are 0.
- Reset:
  - rst_n low sets state to FETCH immediately.
  - pc_write, ir_write, reg_write and mem_write are forced 0 while rst_n is low. Other outputs take their FETCH values; illegal = 0.
  - Reset asserted mid-instruction abandons it; no strobe fires.
- imm_src is combinational from opcode: 0000011/0010011 give I; 0100011 gives S; 1100011 gives B; 1101111 gives J; 0010111 gives U; other opcodes give 000.
- FETCH:
  - adr_src = 0, alu_src_a = 00, alu_src_b = 10, add, result_src = 10.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready = 0; otherwise go to DECODE.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01, add (branch/jump target into ALUOut).
  - Next state by opcode: LD/SD go to MEMADR; R (0110011) goes to EXECR; ADDI (0010011) goes to EXECI; B goes to BRANCH; JAL goes to JAL; AUIPC goes to AUIPC; anything else goes to TRAP.
- MEMADR:
  - alu_src_a = 10, alu_src_b = 01, add.
  - Next state: LD goes to MEMREAD; SD goes to MEMWRITE.
  - funct3 other than 011 goes to TRAP.
- MEMREAD:
  - adr_src = 1, result_src = 00.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src = 01, reg_write = 1, then go to FETCH.
- MEMWRITE:
  - adr_src = 1, mem_write = 1, held every cycle until mem_ready is seen.
  - Then go to FETCH.
- EXECR:
  - alu_src_a = 10, alu_src_b = 00, then go to ALUWB.
  - alu_control from {funct7[5], funct3}: 0_000 add, 1_000 sub, 0_111 and, 0_110 or, 0_010 slt.
  - Any other combination goes to TRAP instead of ALUWB.
- EXECI:
  - alu_src_a = 10, alu_src_b = 01, add, then go to ALUWB.
  - funct3 other than 000 goes to TRAP.
- ALUWB: result_src = 00, reg_write = 1, then go to FETCH.
- BRANCH:
  - alu_src_a = 10, alu_src_b = 00, sub, result_src = 00.
  - pc_write = zero for funct3 000 (beq); pc_write = !zero for funct3 001 (bne).
  - Then go to FETCH.
  - Other funct3 values go to TRAP with pc_write = 0.
- JAL:
  - alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1.
  - Then go to ALUWB, which writes rd = OldPC + 4.
- AUIPC: alu_src_a = 01, alu_src_b = 01, add, then go to ALUWB.
- TRAP: illegal = 1, all strobes 0; stays in TRAP until reset.
- Latency with mem_ready always 1:
  - R, I, AUIPC: 4 cycles.
  - JAL: 4 cycles.
  - LD: 5 cycles.
  - SD: 4 cycles.
  - Branch: 3 cycles.
  - Each mem_ready-low cycle adds one cycle in the waiting state.

Test Plan:
- Reset released, mem_ready = 1, inst = 0x002081B3 (add) -> states 0,1,6,8,0; ir_write and pc_write high in cycle 0; alu_control = 000 in state 6; reg_write in state 8.
- inst = 0x402081B3 (sub), then 0x0000B283 (ld) with mem_ready low for 2 cycles in MEMREAD -> sub: alu_control = 001. ld: states 0,1,2,3,3,3,4, with reg_write and result_src = 01 in state 4.
- inst = 0x0050B423 (sd), mem_ready low for 3 cycles -> mem_write high 4 consecutive cycles with adr_src = 1, then FETCH.
- inst = 0x00000463 (beq) with zero = 1, then bne 0x00001463 with zero = 1 -> beq: pc_write = 1 in BRANCH. bne: pc_write = 0. Both take 3 cycles.
- inst = 0x010000EF (jal) -> imm_src = 011; states 0,1,10,8; pc_write = 1 in state 10; reg_write = 1 in state 8.
- inst = 0x0000007F (bad opcode) -> TRAP by cycle 2 with illegal = 1 and no strobes; rst_n pulsed low mid-MEMWRITE -> mem_write drops immediately and state_dbg = 0.
